// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, oversampling
// points and the receive FIFO entry layout.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP1     = 3'd4,
        ST_STOP2     = 3'd5,
        ST_WAIT_HIGH = 3'd6
    } rx_state_e;

    localparam int unsigned OVERSAMPLE       = 16;
    localparam logic [3:0]  MID_SAMPLE       = 4'd7;
    localparam logic [3:0]  LAST_SAMPLE      = 4'(OVERSAMPLE - 1);
    localparam int unsigned DATA_BITS_OFFSET = 5;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    localparam int unsigned ENTRY_W = $bits(rx_entry_t);

    // Index of the final data bit for a given character-length setting.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        return 3'(data_bits) + 3'(DATA_BITS_OFFSET - 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; a push into a full FIFO
// without a simultaneous pop is dropped and flagged for one clock.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overrun_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;
    logic             overrun_q, overrun_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees the slot in the same clock, so a full FIFO still accepts a push.
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign overrun_d = push_i && full_o && !do_pop;

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign overrun_o = overrun_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: input synchronizer, 16x tick generator, framing FSM and a
// small FWFT receive FIFO holding {ferr, perr, data} per character.
//
// state      | meaning
// IDLE       | line idle, waiting for a low sample to begin a frame
// START      | qualifying the start bit at mid-bit
// DATA       | sampling data bits, LSB first
// PARITY     | sampling the parity bit
// STOP1      | sampling the first stop bit
// STOP2      | sampling the second stop bit
// WAIT_HIGH  | line still low after the frame (break), wait for idle
module uart_rx_core #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 12
) (
    input  logic             app_clk,
    input  logic             app_reset_n,
    input  logic             cfg_rx_en,
    input  logic [1:0]       cfg_data_bits,
    input  logic             cfg_stop_bits,
    input  logic             cfg_pri_en,
    input  logic             cfg_pri_even,
    input  logic [DIV_W-1:0] cfg_baud_div,
    input  logic             rxd,
    output logic [7:0]       rx_data,
    output logic             rx_perr,
    output logic             rx_ferr,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             err_overrun
);
    import uart_rx_pkg::*;

    logic             rxd_meta_q, rxd_s_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_q;
    logic [1:0]       data_bits_q;
    logic             stop2_q, pri_en_q, pri_even_q;
    logic             tick;
    rx_state_e        state_q, state_d;
    logic [3:0]       scnt_q, scnt_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       data_q, data_d;
    logic             perr_q, perr_d, ferr_q, ferr_d;
    logic             push;
    rx_entry_t        push_entry, head_entry;
    logic             unused_full, fifo_empty;

    always_ff @(posedge app_clk) begin
        if (!app_reset_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // Divisor down-counter: terminal count 0 gives one tick every div+1 clocks.
    assign tick      = (div_cnt_q == '0);
    assign div_cnt_d = tick ? div_q : div_cnt_q - DIV_W'(1);

    // Configuration tracks the inputs while idle and is frozen for the frame.
    always_ff @(posedge app_clk) begin
        if (!app_reset_n) begin
            div_q       <= '0;
            data_bits_q <= '0;
            stop2_q     <= 1'b0;
            pri_en_q    <= 1'b0;
            pri_even_q  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            div_q       <= cfg_baud_div;
            data_bits_q <= cfg_data_bits;
            stop2_q     <= cfg_stop_bits;
            pri_en_q    <= cfg_pri_en;
            pri_even_q  <= cfg_pri_even;
        end
    end

    always_ff @(posedge app_clk) begin
        if (!app_reset_n) begin
            div_cnt_q <= '0;
            state_q   <= ST_IDLE;
            scnt_q    <= '0;
            bcnt_q    <= '0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            state_q   <= state_d;
            scnt_q    <= scnt_d;
            bcnt_q    <= bcnt_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        if (state_q != ST_IDLE && !cfg_rx_en) begin
            state_d = ST_IDLE;
        end else if (tick) begin
            scnt_d = scnt_q + 4'd1;
            unique case (state_q)
                ST_IDLE: begin
                    if (cfg_rx_en && !rxd_s_q) begin
                        state_d = ST_START;
                        scnt_d  = '0;
                        bcnt_d  = '0;
                        data_d  = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                ST_START: begin
                    if (scnt_q == MID_SAMPLE) begin
                        scnt_d  = '0;
                        state_d = rxd_s_q ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (scnt_q == LAST_SAMPLE) begin
                        data_d[bcnt_q] = rxd_s_q;
                        bcnt_d         = bcnt_q + 3'd1;
                        if (bcnt_q == last_bit_idx(data_bits_q)) begin
                            state_d = pri_en_q ? ST_PARITY : ST_STOP1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (scnt_q == LAST_SAMPLE) begin
                        perr_d  = pri_even_q ? (^data_q ^ rxd_s_q) : ~(^data_q ^ rxd_s_q);
                        state_d = ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (scnt_q == LAST_SAMPLE) begin
                        ferr_d = ferr_q | ~rxd_s_q;
                        if (stop2_q) begin
                            state_d = ST_STOP2;
                        end else begin
                            push    = 1'b1;
                            state_d = rxd_s_q ? ST_IDLE : ST_WAIT_HIGH;
                        end
                    end
                end
                ST_STOP2: begin
                    if (scnt_q == LAST_SAMPLE) begin
                        ferr_d  = ferr_q | ~rxd_s_q;
                        push    = 1'b1;
                        state_d = rxd_s_q ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxd_s_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign push_entry = {ferr_d, perr_q, data_q};

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (app_clk),
        .rst_ni    (app_reset_n),
        .push_i    (push),
        .wdata_i   (push_entry),
        .pop_i     (rx_ready),
        .rdata_o   (head_entry),
        .full_o    (unused_full),
        .empty_o   (fifo_empty),
        .overrun_o (err_overrun)
    );

    assign rx_data  = head_entry.data;
    assign rx_perr  = head_entry.perr;
    assign rx_ferr  = head_entry.ferr;
    assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized
// frames, checked against a queue of expected characters.
module tb_uart_rx_core;
    localparam int DEPTH = 4;
    localparam int DIV_W = 12;

    logic             app_clk;
    logic             app_reset_n;
    logic             cfg_rx_en;
    logic [1:0]       cfg_data_bits;
    logic             cfg_stop_bits;
    logic             cfg_pri_en;
    logic             cfg_pri_even;
    logic [DIV_W-1:0] cfg_baud_div;
    logic             rxd;
    logic [7:0]       rx_data;
    logic             rx_perr;
    logic             rx_ferr;
    logic             rx_valid;
    logic             rx_ready;
    logic             err_overrun;

    int         total = 0;
    int         bad = 0;
    logic [9:0] model_q[$];
    int         exp_ovr = 0;
    int         ovr_seen = 0;
    time        start_t = 0;
    time        rise_t = 0;
    logic       valid_prev = 1'b0;

    uart_rx_core #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .app_clk       (app_clk),
        .app_reset_n   (app_reset_n),
        .cfg_rx_en     (cfg_rx_en),
        .cfg_data_bits (cfg_data_bits),
        .cfg_stop_bits (cfg_stop_bits),
        .cfg_pri_en    (cfg_pri_en),
        .cfg_pri_even  (cfg_pri_even),
        .cfg_baud_div  (cfg_baud_div),
        .rxd           (rxd),
        .rx_data       (rx_data),
        .rx_perr       (rx_perr),
        .rx_ferr       (rx_ferr),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .err_overrun   (err_overrun)
    );

    initial begin
        app_clk = 1'b0;
        forever #5 app_clk = ~app_clk;
    end

    always @(negedge app_clk) begin
        if (err_overrun === 1'b1) ovr_seen++;
        if (rx_valid === 1'b1 && valid_prev !== 1'b1) rise_t = $time;
        valid_prev = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(negedge app_clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        idle_clks(16 * (int'(cfg_baud_div) + 1));
    endtask

    // Agent transmit plus reference: expected entry derived from the frame rules.
    task automatic send_frame(input logic [7:0] d, input logic par_inv, input logic stop_err);
        int         nb;
        logic [7:0] m;
        logic       pb;
        logic       perr;
        nb = int'(cfg_data_bits) + 5;
        m  = d & 8'((1 << nb) - 1);
        perr = 1'b0;
        start_t = $time;
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(m[i]);
        if (cfg_pri_en) begin
            pb = (cfg_pri_even ? ^m : ~^m) ^ par_inv;
            perr = ((($countones(m) + int'(pb)) % 2) != (cfg_pri_even ? 0 : 1));
            send_bit(pb);
        end
        send_bit(~stop_err);
        if (cfg_stop_bits) send_bit(~stop_err);
        if (model_q.size() < DEPTH) model_q.push_back({stop_err, perr, m});
        else exp_ovr++;
    endtask

    task automatic drain(input string tag);
        logic [9:0] e;
        int         w;
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            w = 0;
            while (rx_valid !== 1'b1 && w < 200) begin
                @(negedge app_clk);
                w++;
            end
            chk({tag, "_valid"}, 32'(rx_valid), 32'(1));
            chk({tag, "_data"},  32'(rx_data),  32'(e[7:0]));
            chk({tag, "_perr"},  32'(rx_perr),  32'(e[8]));
            chk({tag, "_ferr"},  32'(rx_ferr),  32'(e[9]));
            rx_ready = 1'b1;
            @(negedge app_clk);
            rx_ready = 1'b0;
        end
        chk({tag, "_empty"}, 32'(rx_valid), 32'(0));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_data"},    32'(rx_data),     32'(0));
        chk({tag, "_perr"},    32'(rx_perr),     32'(0));
        chk({tag, "_ferr"},    32'(rx_ferr),     32'(0));
        chk({tag, "_valid"},   32'(rx_valid),    32'(0));
        chk({tag, "_overrun"}, 32'(err_overrun), 32'(0));
    endtask

    initial begin
        logic [7:0] pd;
        int         base_ovr;
        int         base_exp;
        int         nfr;

        rxd           = 1'b1;
        rx_ready      = 1'b0;
        app_reset_n   = 1'b0;
        cfg_rx_en     = 1'b1;
        cfg_data_bits = 2'd3;
        cfg_stop_bits = 1'b0;
        cfg_pri_en    = 1'b0;
        cfg_pri_even  = 1'b0;
        cfg_baud_div  = '0;
        idle_clks(4);
        chk_zero_outputs("reset");
        app_reset_n = 1'b1;
        idle_clks(5);

        send_frame(8'hA5, 1'b0, 1'b0);
        idle_clks(4);
        chk("a5_latency", 32'((rise_t > start_t) && (rise_t - start_t <= 162 * 10)), 32'(1));
        drain("a5");

        cfg_data_bits = 2'd2;
        cfg_pri_en    = 1'b1;
        cfg_pri_even  = 1'b1;
        cfg_stop_bits = 1'b1;
        send_frame(8'h35, 1'b1, 1'b0);
        send_frame(8'h35, 1'b0, 1'b0);
        idle_clks(10);
        drain("p7e2");

        cfg_data_bits = 2'd3;
        cfg_pri_en    = 1'b0;
        cfg_stop_bits = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1);
        rxd = 1'b1;
        idle_clks(160);
        send_frame(8'h3D, 1'b0, 1'b0);
        idle_clks(10);
        drain("ferr");

        base_ovr = ovr_seen;
        base_exp = exp_ovr;
        for (int d = 1; d <= 5; d++) send_frame(8'(d), 1'b0, 1'b0);
        idle_clks(20);
        chk("ovr_pulses", 32'(ovr_seen - base_ovr), 32'(exp_ovr - base_exp));
        drain("ovr");

        rxd = 1'b0;
        idle_clks(3 * 160);
        model_q.push_back(10'h200);
        rxd = 1'b1;
        idle_clks(160);
        drain("break");

        rxd = 1'b0;
        idle_clks(6);
        rxd = 1'b1;
        idle_clks(200);
        chk("glitch_none", 32'(rx_valid), 32'(0));

        send_bit(1'b0);
        send_bit(1'b1);
        rxd = 1'b0;
        idle_clks(8);
        cfg_rx_en = 1'b0;
        idle_clks(8);
        rxd = 1'b1;
        idle_clks(200);
        cfg_rx_en = 1'b1;
        idle_clks(200);
        chk("rxen_drop_none", 32'(rx_valid), 32'(0));

        send_frame(8'h77, 1'b0, 1'b0);
        pd = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(pd[i]);
        rxd = pd[3];
        idle_clks(8);
        app_reset_n = 1'b0;
        idle_clks(2);
        chk_zero_outputs("midrst");
        rxd = 1'b1;
        app_reset_n = 1'b1;
        model_q.delete();
        idle_clks(200);
        chk("midrst_empty", 32'(rx_valid), 32'(0));
        send_frame(8'h5A, 1'b0, 1'b0);
        idle_clks(10);
        drain("after_rst");

        for (int r = 0; r < 6; r++) begin
            cfg_data_bits = 2'($urandom_range(0, 3));
            cfg_pri_en    = 1'($urandom_range(0, 1));
            cfg_pri_even  = 1'($urandom_range(0, 1));
            cfg_stop_bits = 1'($urandom_range(0, 1));
            cfg_baud_div  = DIV_W'($urandom_range(0, 2));
            rxd = 1'b1;
            idle_clks(50);
            nfr = int'($urandom_range(1, 3));
            for (int k = 0; k < nfr; k++)
                send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            idle_clks(10);
            drain("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Synthesizable UART receiver that consumes the serial line driven by the UART bench agent's transmit side (`sin`). It runs on one clock, uses 16x oversampling and a programmable baud divisor, and supports 5–8 data bits, optional even/odd parity and 1 or 2 stop bits. Received characters and their per-character error flags go into a small FIFO, which the 8051 register interface pops.

## Interface
- `FIFO_DEPTH`, 4, number of receive entries; must be a power of two, ≥2.
- `DIV_W`, 12, width of the baud divisor.

Ports:
- `app_clk`  in  1  system clock.
- `app_reset_n`  in  1  synchronous, active-low reset.
- `cfg_rx_en`  in  1  receiver enable.
- `cfg_data_bits`  in  2  data bits = value + 5.
- `cfg_stop_bits`  in  1  0: one stop bit, 1: two stop bits.
- `cfg_pri_en`  in  1  parity bit present.
- `cfg_pri_even`  in  1  1: even parity, 0: odd parity.
- `cfg_baud_div`  in  DIV_W  16x tick every `cfg_baud_div`+1 clocks.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  8  FIFO head data, LSB-aligned; unused upper bits are 0.
- `rx_perr`  out  1  head entry has a parity error.
- `rx_ferr`  out  1  head entry has a framing error.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  pop the head when `rx_valid` is high.
- `err_overrun`  out  1  one-clock pulse when a character is dropped because the FIFO is full.

## Operation
- `rxd` passes through a 2-flop synchronizer to give `rxd_s`. Both flops reset to 1.
- Tick generator: a counter counts 0..`cfg_baud_div`, then wraps. It asserts `tick` on the wrap. With `cfg_baud_div`=0, `tick` is high every clock.
- Sample counter `scnt` (4 bits) advances on each `tick`.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE:
  - `rxd_s`=0 with `cfg_rx_en`=1 → START, `scnt`=0.
  - All cfg inputs are latched at this point and held for the whole frame.
- START:
  - At `scnt`=7 (mid-bit), if `rxd_s`=1 the start was a glitch → IDLE.
  - Otherwise `scnt`=0 → DATA.
- DATA: sample on every 16th tick after mid-start (`scnt`=15), shifting LSB first. After N bits → PARITY if parity enabled, else STOP1.
- PARITY: sample the bit. Even mode: perr = XOR(data, bit) ≠ 0. Odd mode: perr = XOR(data, bit) ≠ 1.
- STOP1: a low sample sets ferr. Then:
  - two stop bits configured → STOP2;
  - else push the character and go to IDLE, or to WAIT_HIGH if `rxd_s`=0.
- STOP2: a low sample sets ferr. Then push, and go to IDLE or WAIT_HIGH by the same rule.
- WAIT_HIGH: stay until `rxd_s`=1, then IDLE. This is break handling: a break yields one entry with data 0 and ferr=1, not a stream of entries.
- Push: {ferr, perr, data} is written into the FIFO.
- `cfg_rx_en` falling mid-frame: return to IDLE, discard the partial character, keep the FIFO contents.

## Timing
- Reset value of every output is 0: `rx_data`, `rx_perr`, `rx_ferr`, `rx_valid`, `err_overrun`.
- Reset puts the FSM in IDLE, clears all counters, and empties the FIFO. Reset mid-frame aborts the frame.
- Latency: `rx_valid` rises 1 clock after the tick that samples the final stop bit. Worst-case path from a `rxd` edge adds 2 clocks for the synchronizer.
- Bit period is 16·(`cfg_baud_div`+1) clocks. With div=0 the period is 16 clocks, which matches the agent.
- The FIFO is first-word fall-through. A pop happens on a clock where `rx_valid`=1 and `rx_ready`=1. The next entry, or `rx_valid`=0, is visible the following clock.
- `rx_ready` while empty is ignored.
- Push while full, with no pop in the same clock: the new character is dropped, `err_overrun` pulses for 1 clock, and existing entries are unchanged.
- Push and pop in the same clock while full: the pop is taken first and the push is accepted; no overrun.
- Push and pop in the same clock while holding one entry: `rx_valid` stays 1 and the new entry becomes the head.
- FIFO read and write pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally. Full means the pointers differ only in their MSB.
- Back-to-back frames: the FSM re-arms in IDLE within the second half of the last stop bit, so a start bit that immediately follows is detected.

## Structure
- Shared package or defines file `uart_rx_pkg` holds:
  - state encodings;
  - `OVERSAMPLE`=16 and `MID_SAMPLE`=7;
  - the data-bit offset of 5;
  - the FIFO entry layout {ferr, perr, data[7:0]} (10 bits).
- One sub-module: `uart_rx_fifo`, a synchronous FWFT FIFO parameterized by width and depth, with full/empty outputs and overrun detect.
- Tick generator, synchronizer and FSM live in `uart_rx_core`.

## Test plan
- Break line: agent drives `rxd` low for 3 frame times → exactly one entry with data 0x00 and `rx_ferr`=1; no further entries until the line returns high.
- 8N1, div=0: agent writes 0xA5 → `rx_data`=0xA5, `rx_valid`=1 within 162 clocks of the start edge, `rx_perr`=0, `rx_ferr`=0.
- 7 data bits, even parity, 2 stop bits: agent sends 0x35 with the parity bit inverted → `rx_data`=0x35, `rx_perr`=1. A correct 0x35 → `rx_perr`=0.
- Stop-bit error (agent `stop_err_check`=1), 8N1, data 0x3C → `rx_data`=0x3C, `rx_ferr`=1. The next frame, 0x3D, is clean.
- Overrun: `rx_ready`=0, agent sends 0x01..0x05 back-to-back → FIFO holds 0x01..0x04 and `err_overrun` pulses once. Then draining with `rx_ready`=1 returns 0x01, 0x02, 0x03, 0x04 in that order, then `rx_valid`=0.
- Robustness, in sequence:
  - a 6-clock low glitch on `rxd` → no entry;
  - `app_reset_n` low for 2 clocks during data bit 3 → all outputs 0;
  - the following frame, 0x5A, is received correctly.
